// File: rtl/vid_in_axis_bridge_pkg.sv
// Shared types for the parallel-video to AXI4-Stream bridge: FSM states, FIFO word layout
// and a configuration sanity helper.
package vid_in_axis_bridge_pkg;

    localparam int VID_DATA_W = 16;

    typedef enum logic [1:0] {
        S_UNLOCK,
        S_SOF,
        S_FRAME
    } vid_fsm_t;

    typedef struct packed {
        logic                  sof;
        logic                  eol;
        logic [VID_DATA_W-1:0] data;
    } vid_word_t;

    function automatic bit vid_cfg_ok(input int active_pix, input int active_lines, input int depth);
        return (active_pix > 0) && (active_lines > 0) && (depth >= active_pix) &&
               (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/vid_in_axis_bridge_if.sv
// AXI4-Stream video channel (tdata/tvalid/tready/tuser=SOF/tlast=EOL) between bridge and sink.
interface vid_in_axis_bridge_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tuser;
    logic              tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a write into a full FIFO is taken when a pop
// happens in the same cycle. Read data is forced to zero while empty.
module axis_sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/vid_in_axis_bridge.sv
// Parallel video (vsync/de/pixel) to AXI4-Stream with SOF on tuser and EOL on tlast.
// Define VID_LINE_CHECK_EN to enable sticky line-length / line-count error flags.
module vid_in_axis_bridge
    import vid_in_axis_bridge_pkg::*;
#(
    parameter int DATA_W       = VID_DATA_W,
    parameter int ACTIVE_PIX   = 640,
    parameter int ACTIVE_LINES = 480,
    parameter int FIFO_DEPTH   = 1024
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic                  vid_vsync,
    input  logic                  vid_de,
    input  logic [DATA_W-1:0]     vid_data,
    vid_in_axis_bridge_if.master  m_axis,
    output logic                  locked,
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic                  err_line_len,
    output logic                  err_frame_len
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic              sof;
        logic              eol;
        logic [DATA_W-1:0] data;
    } word_t;

    if (!vid_cfg_ok(ACTIVE_PIX, ACTIVE_LINES, FIFO_DEPTH)) begin : g_cfg_err
        $error("vid_in_axis_bridge: invalid ACTIVE_PIX/ACTIVE_LINES/FIFO_DEPTH");
    end

    logic              vsync_p1;
    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic              vs_rise;
    logic              eol;
    logic              wr_req;
    logic              pop;
    logic              drop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [AW:0]       fifo_count;
    word_t             wr_word;
    word_t             rd_word;
    vid_fsm_t          state;
    vid_fsm_t          state_nxt;

    // Stage p1: input capture
    always_ff @(posedge pclk) begin
        if (rst) begin
            vsync_p1 <= 1'b0;
            vld_p1   <= 1'b0;
        end else begin
            vsync_p1 <= vid_vsync;
            vld_p1   <= vid_de;
        end
    end

    always_ff @(posedge pclk) begin
        data_p1 <= vid_data;
    end

    assign vs_rise = vid_vsync & ~vsync_p1;
    assign eol     = vld_p1 & ~vid_de;

    always_ff @(posedge pclk) begin
        if (rst) state <= S_UNLOCK;
        else     state <= state_nxt;
    end

    // A pixel coinciding with vs_rise is written under the current state, so it stays in the old frame.
    always_comb begin
        state_nxt = state;
        case (state)
            S_UNLOCK: if (vs_rise) state_nxt = S_SOF;
            S_SOF: begin
                if (vs_rise)     state_nxt = S_SOF;
                else if (vld_p1) state_nxt = S_FRAME;
            end
            S_FRAME:  if (vs_rise) state_nxt = S_SOF;
            default:  state_nxt = S_UNLOCK;
        endcase
    end

    assign locked    = (state != S_UNLOCK);
    assign wr_req    = vld_p1 & locked;
    assign fifo_full = (fifo_count == (AW+1)'(FIFO_DEPTH));
    assign pop       = ~fifo_empty & m_axis.tready;
    assign drop      = wr_req & fifo_full & ~pop;

    assign wr_word.sof  = (state == S_SOF);
    assign wr_word.eol  = eol;
    assign wr_word.data = data_p1;

    // Stage p2: FIFO write; FWFT read side drives the stream directly
    axis_sync_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (pclk),
        .rst     (rst),
        .wr_en   (wr_req),
        .wr_data (wr_word),
        .rd_en   (pop),
        .rd_data (rd_word),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign m_axis.tvalid = ~fifo_empty;
    assign m_axis.tdata  = rd_word.data;
    assign m_axis.tuser  = rd_word.sof;
    assign m_axis.tlast  = rd_word.eol;

    // A drop in the same cycle as ovf_clr keeps the flag set.
    always_ff @(posedge pclk) begin
        if (rst)          overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

`ifdef VID_LINE_CHECK_EN
    logic [15:0] pix_cnt;
    logic [15:0] line_cnt;
    logic [15:0] line_cnt_now;
    logic        eol_wr;

    assign eol_wr       = wr_req & eol;
    assign line_cnt_now = line_cnt + {15'd0, eol_wr};

    always_ff @(posedge pclk) begin
        if (rst) begin
            pix_cnt       <= '0;
            line_cnt      <= '0;
            err_line_len  <= 1'b0;
            err_frame_len <= 1'b0;
        end else begin
            if (eol_wr) begin
                pix_cnt <= '0;
                if (pix_cnt + 16'd1 != 16'(ACTIVE_PIX)) err_line_len <= 1'b1;
            end else if (wr_req) begin
                pix_cnt <= pix_cnt + 16'd1;
            end
            // The line ending in the vs_rise cycle still counts toward the closing frame.
            if (vs_rise) begin
                line_cnt <= '0;
                if (state == S_FRAME && line_cnt_now != 16'(ACTIVE_LINES)) err_frame_len <= 1'b1;
            end else if (eol_wr) begin
                line_cnt <= line_cnt + 16'd1;
            end
        end
    end
`else
    assign err_line_len  = 1'b0;
    assign err_frame_len = 1'b0;
`endif

endmodule
